spi_slave_mode: RTL
===================

Name: spi_slave_mode

Overview:
- Parametrised successor of the board's Pi-to-ARM SPI register bridge. Runs in the Clk domain with oversampled SPI pins.
- Two register banks:
  - mosi bank: SPI master writes, processor reads.
  - miso bank: processor writes, SPI master reads.
- Adds over the previous generation: configurable word width and bank depth, all four SPI modes (CPOL/CPHA), asynchronous reset, abort detection, and a receive strobe.

Parameters:
- DATA_W, 32: payload bits per frame and bank word width (8..32).
- ADDR_W, 4: register address bits; each bank has 2**ADDR_W entries (1..7).
- CPOL, 0: SPI_CLK idle level.
- CPHA, 0: 0 = sample on leading edge, 1 = sample on trailing edge.
- SYNC_STAGES, 2: flip-flop stages in the SPI_CLK/SPI_CS synchronisers (>=2).

Ports:
- Clk, input, 1: system clock.
- Reset_n, input, 1: reset, asynchronous, active-low.
- SPI_CLK, input, 1: SPI clock, asynchronous.
- SPI_CS, input, 1: chip select, active-low, asynchronous.
- SPI_MOSI, input, 1: master-out data.
- SPI_MISO, output, 1: slave-out data, registered.
- Data_WE, input, 1: processor write to the miso bank.
- Data_Addr, input, 32: byte address; word index = Data_Addr[ADDR_W+1:2].
- Data_Write, input, DATA_W: write data to the miso bank.
- Data_Read, output, DATA_W: mosi bank word at the word index; combinational read.
- Rx_Valid, output, 1: one-cycle pulse when the mosi bank is written.
- Rx_Addr, output, ADDR_W: address of the last mosi write; held until the next write.
- Frame_Err, output, 1: one-cycle pulse on an aborted frame.

Behaviour:
- Reset (Reset_n low, async):
  - Both banks cleared to 0, state IDLE, counter 0.
  - SPI_MISO, Rx_Valid, Rx_Addr and Frame_Err all 0.
- Synchronisation and edge detection:
  - SPI_CLK and SPI_CS each pass through SYNC_STAGES flops, then a one-flop edge detector.
  - Pin edge to internal event latency: SYNC_STAGES+1 Clk cycles.
  - Requirement on the master: SPI_CLK high and low times >= SYNC_STAGES+2 Clk periods.
- Edge definitions:
  - Leading edge = synchronised SPI_CLK leaving the CPOL level; trailing edge = returning to it.
  - Sample edge = leading if CPHA=0, else trailing. Shift edge = the other one.
- Frame format, MSB first:
  - 8-bit header: bit7 = W (1 = master write), bits[ADDR_W-1:0] = address, other bits ignored.
  - Followed by DATA_W payload bits.
- State machine:
  - IDLE: on the CS falling event, clear the counter and the rx/tx shift registers, drive SPI_MISO=0, go to HEADER.
  - HEADER: each sample edge shifts MOSI into rx and increments the counter. At count 8:
    - latch the header;
    - load tx <= miso_bank[addr] (bank read occurs that cycle);
    - go to DATA.
  - DATA: each sample edge shifts rx and increments the counter. At count 8+DATA_W:
    - if W=1, write mosi_bank[addr] <= rx payload on the next Clk edge, pulse Rx_Valid and update Rx_Addr in the same cycle as the write;
    - go to DONE.
  - DONE: further SPI_CLK edges are ignored and the counter saturates. On the CS rising event go to IDLE.
- MISO driving:
  - During HEADER, shift edges drive 0.
  - During DATA, each shift edge does SPI_MISO <= tx[DATA_W-1], then tx <<= 1. This puts the word MSB on the line before the first payload sample edge in both CPHA settings.
  - In DONE and IDLE, SPI_MISO = 0.
- Abort:
  - A CS rising event in HEADER or DATA goes to IDLE with no bank write and pulses Frame_Err for one cycle.
  - A CS rising event in the same cycle as the final sample edge counts as completion: the write happens and Frame_Err stays 0.
- Read and write collisions:
  - Data_WE to the same miso address in the same cycle as the tx load: tx gets the old value.
  - Data_Read in the same cycle as an SPI write: shows the old value; the new value appears the next cycle.
- Reset mid-frame: immediate return to IDLE and all outputs 0. A CS low already active at reset release does not start a frame; the block waits for a fresh falling event.

Decomposition:
- Package spi_pkg:
  - state typedef {IDLE, HEADER, DATA, DONE};
  - HDR_W = 8;
  - HDR_WBIT = 7.
- Sub-module spi_sync_edge (parameter STAGES): synchroniser plus rise/fall pulse outputs, instantiated for SPI_CLK and for SPI_CS.

Test Plan:
- Mode 0 write: header 0x83, payload 0xDEADBEEF -> mosi[3]=0xDEADBEEF; Rx_Valid one pulse with Rx_Addr=3; Data_Read at Data_Addr=0x0C returns 0xDEADBEEF.
- Mode 0 read: processor writes miso[5]=0xA5A5_0F0F; header 0x05 -> MISO bits 9..40 = 0xA5A50F0F MSB first; mosi bank unchanged; no Rx_Valid.
- Modes 1, 2, 3 (CPOL/CPHA params) repeat both scenarios with DATA_W=16, value 0x1234 -> identical bank contents and MISO stream.
- Abort: CS rises after 20 of 40 bits on a write to address 2 -> mosi[2] unchanged, Frame_Err one pulse, next full frame succeeds.
- Collision: Data_WE to miso[1]=0x55 in the tx-load cycle of a read of address 1 with old value 0x11 -> MISO streams 0x11; the next read returns 0x55.
- Reset: Reset_n low at bit 30 -> SPI_MISO=0 and no write. A CS held low across the reset release produces no frame until CS toggles.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and frame constants for the SPI register bridge.
package spi_pkg;

   typedef enum logic [1:0] {IDLE, HEADER, DATA, DONE} state_t;

   localparam int HDR_W    = 8;
   localparam int HDR_WBIT = 7;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin followed by a one-flop
// edge detector producing single-cycle rise/fall pulses.
module spi_sync_edge #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic Clk,
   input  logic Reset_n,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_reg;
   logic              prev_reg;

   generate
      for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
         always_ff @(posedge Clk or negedge Reset_n) begin
            if (!Reset_n) begin
               sync_reg[gi] <= RST_VAL;
            end else begin
               sync_reg[gi] <= (gi == 0) ? din : sync_reg[(gi == 0) ? 0 : gi - 1];
            end
         end
      end
   endgenerate

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         prev_reg <= RST_VAL;
      end else begin
         prev_reg <= sync_reg[STAGES-1];
      end
   end

   assign rise = sync_reg[STAGES-1] & ~prev_reg;
   assign fall = ~sync_reg[STAGES-1] & prev_reg;

endmodule

// File: rtl/spi_slave_mode.sv
// Oversampled SPI slave bridging two register banks: the master writes the
// mosi bank and reads the miso bank; the processor does the opposite.
module spi_slave_mode
   import spi_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 4,
   parameter int CPOL        = 0,
   parameter int CPHA        = 0,
   parameter int SYNC_STAGES = 2
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              SPI_CLK,
   input  logic              SPI_CS,
   input  logic              SPI_MOSI,
   output logic              SPI_MISO,
   input  logic              Data_WE,
   input  logic [31:0]       Data_Addr,
   input  logic [DATA_W-1:0] Data_Write,
   output logic [DATA_W-1:0] Data_Read,
   output logic              Rx_Valid,
   output logic [ADDR_W-1:0] Rx_Addr,
   output logic              Frame_Err
);

   localparam int FRAME_BITS = HDR_W + DATA_W;
   localparam int CNT_W      = $clog2(FRAME_BITS + 1);
   localparam int DEPTH      = 2 ** ADDR_W;

   logic clk_rise, clk_fall, cs_rise, cs_fall;
   logic lead_ev, trail_ev, sample_ev, shift_ev;

   logic [SYNC_STAGES-1:0] mosi_sync_reg;

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next, cnt_inc;
   logic [DATA_W-1:0] rx_reg, rx_next, rx_shift;
   logic [DATA_W-1:0] tx_reg, tx_next;
   logic              hdr_w_reg, hdr_w_next;
   logic [ADDR_W-1:0] hdr_addr_reg, hdr_addr_next;
   logic              miso_reg, miso_next;
   logic              wr_en, frame_err_next, last_sample;
   logic [ADDR_W-1:0] load_addr, data_idx;

   logic [DATA_W-1:0] mosi_bank [DEPTH];
   logic [DATA_W-1:0] miso_bank [DEPTH];

   logic              rx_valid_reg, frame_err_reg;
   logic [ADDR_W-1:0] rx_addr_reg;
   logic              unused_addr_bits;

   // CS synchroniser resets to "selected" so a CS already low at reset
   // release never looks like a falling edge.
   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL != 0)) u_clk_sync (
      .Clk    (Clk),
      .Reset_n(Reset_n),
      .din    (SPI_CLK),
      .rise   (clk_rise),
      .fall   (clk_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_cs_sync (
      .Clk    (Clk),
      .Reset_n(Reset_n),
      .din    (SPI_CS),
      .rise   (cs_rise),
      .fall   (cs_fall)
   );

   // MOSI is delayed by the same depth so it lines up with the clock events.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         mosi_sync_reg <= '0;
      end else begin
         mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], SPI_MOSI};
      end
   end

   assign lead_ev   = (CPOL != 0) ? clk_fall : clk_rise;
   assign trail_ev  = (CPOL != 0) ? clk_rise : clk_fall;
   assign sample_ev = (CPHA != 0) ? trail_ev : lead_ev;
   assign shift_ev  = (CPHA != 0) ? lead_ev  : trail_ev;

   assign rx_shift    = {rx_reg[DATA_W-2:0], mosi_sync_reg[SYNC_STAGES-1]};
   assign cnt_inc     = cnt_reg + CNT_W'(1);
   assign load_addr   = rx_shift[ADDR_W-1:0];
   assign last_sample = sample_ev && (cnt_inc == CNT_W'(FRAME_BITS));
   assign data_idx    = Data_Addr[ADDR_W+1:2];

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      rx_next        = rx_reg;
      tx_next        = tx_reg;
      hdr_w_next     = hdr_w_reg;
      hdr_addr_next  = hdr_addr_reg;
      miso_next      = miso_reg;
      wr_en          = 1'b0;
      frame_err_next = 1'b0;

      case (state_reg)
         IDLE: begin
            miso_next = 1'b0;
            if (cs_fall) begin
               cnt_next   = '0;
               rx_next    = '0;
               tx_next    = '0;
               state_next = HEADER;
            end
         end
         HEADER: begin
            if (sample_ev) begin
               rx_next  = rx_shift;
               cnt_next = cnt_inc;
               if (cnt_inc == CNT_W'(HDR_W)) begin
                  hdr_w_next    = rx_shift[HDR_WBIT];
                  hdr_addr_next = load_addr;
                  tx_next       = miso_bank[load_addr];
                  state_next    = DATA;
               end
            end else if (shift_ev) begin
               miso_next = 1'b0;
            end
            if (cs_rise) begin
               miso_next      = 1'b0;
               frame_err_next = 1'b1;
               state_next     = IDLE;
            end
         end
         DATA: begin
            if (sample_ev) begin
               rx_next  = rx_shift;
               cnt_next = cnt_inc;
               if (last_sample) begin
                  wr_en      = hdr_w_reg;
                  miso_next  = 1'b0;
                  state_next = DONE;
               end
            end else if (shift_ev) begin
               miso_next = tx_reg[DATA_W-1];
               tx_next   = {tx_reg[DATA_W-2:0], 1'b0};
            end
            // A deselect coinciding with the final sample still completes.
            if (cs_rise) begin
               miso_next      = 1'b0;
               frame_err_next = !last_sample;
               state_next     = IDLE;
            end
         end
         DONE: begin
            miso_next = 1'b0;
            if (cs_rise) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         rx_reg        <= '0;
         tx_reg        <= '0;
         hdr_w_reg     <= 1'b0;
         hdr_addr_reg  <= '0;
         miso_reg      <= 1'b0;
         frame_err_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         rx_reg        <= rx_next;
         tx_reg        <= tx_next;
         hdr_w_reg     <= hdr_w_next;
         hdr_addr_reg  <= hdr_addr_next;
         miso_reg      <= miso_next;
         frame_err_reg <= frame_err_next;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mosi_bank[i] <= '0;
            miso_bank[i] <= '0;
         end
         rx_valid_reg <= 1'b0;
         rx_addr_reg  <= '0;
      end else begin
         rx_valid_reg <= wr_en;
         if (wr_en) begin
            mosi_bank[hdr_addr_reg] <= rx_shift;
            rx_addr_reg             <= hdr_addr_reg;
         end
         if (Data_WE) begin
            miso_bank[data_idx] <= Data_Write;
         end
      end
   end

   assign Data_Read = mosi_bank[data_idx];
   assign SPI_MISO  = miso_reg;
   assign Rx_Valid  = rx_valid_reg;
   assign Rx_Addr   = rx_addr_reg;
   assign Frame_Err = frame_err_reg;

   assign unused_addr_bits = ^{Data_Addr[31:ADDR_W+2], Data_Addr[1:0]};

endmodule
